scan_data_register: RTL and testbench
=====================================

SCAN_DATA_REGISTER -- requirements
Module: scan_data_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, scan chain length in bits (>= 1).
REQ-002 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit reset value of the update register.
REQ-003 SHALL have port ClockDR  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port TDI  input  1  serial scan data in.
REQ-006 SHALL have port CaptureDR  input  1  load ParallelIn into the shift register.
REQ-007 SHALL have port ShiftDR  input  1  shift one bit TDI -> TDO per edge.
REQ-008 SHALL have port UpdateDR  input  1  copy the shift register into the update register.
REQ-009 SHALL have port Mode  input  1  1 = drive ParallelOut from the update register; 0 = transparent.
REQ-010 SHALL have port ParallelIn  input  WIDTH  system-side data, captured on CaptureDR.
REQ-011 SHALL have port ParallelOut  output  WIDTH  system-side data out.
REQ-012 SHALL have port TDO  output  1  serial scan data out, driven by a flop.
REQ-013 SHALL have port ShiftCount  output  $clog2(WIDTH+1)  bits shifted since the last capture or reset.
REQ-014 SHALL have port ShiftDone  output  1  high when ShiftCount == WIDTH.

Function
REQ-015 Shift register SR[WIDTH-1:0]: on CaptureDR SHALL load SR <= ParallelIn; else on ShiftDR SHALL load SR <= {TDI, SR[WIDTH-1:1]}; otherwise SR SHALL hold.
REQ-016 CaptureDR SHALL take priority over ShiftDR when both are high.
REQ-017 TDO SHALL equal SR[0], so the first bit out after capture is ParallelIn[0] and shift latency TDI -> TDO is WIDTH edges.
REQ-018 On UpdateDR the update register UR SHALL load the pre-edge SR value, including when ShiftDR or CaptureDR is high in the same cycle.
REQ-019 ParallelOut SHALL be combinational: Mode ? UR : ParallelIn.
REQ-020 ShiftCount SHALL clear to 0 on CaptureDR, increment by 1 per ShiftDR edge, and saturate at WIDTH without wrapping.
REQ-021 ShiftDone SHALL be combinational from ShiftCount.
REQ-022 With WIDTH = 1, SR SHALL be a single flop with TDO = SR[0], and the capture and shift rules SHALL be unchanged.

Reset
REQ-023 While Reset is high at a ClockDR edge: SR <= 0, UR <= RESET_VALUE, ShiftCount <= 0; Reset SHALL take priority over all other controls.
REQ-024 After reset: TDO = 0, ShiftDone = 0, ParallelOut = Mode ? RESET_VALUE : ParallelIn.
REQ-025 Reset asserted mid-shift SHALL discard partial shift contents, and UR SHALL NOT be updated in that cycle.

Configuration
REQ-026 Macro SCAN_DR_BYPASS_EN, when defined, SHALL add port Bypass (input, 1 bit) and a 1-bit bypass flop BB.
REQ-027 With SCAN_DR_BYPASS_EN defined and Bypass = 1:
  - BB <= TDI & ShiftDR on every edge.
  - TDO = BB.
  - SR, UR and ShiftCount hold.
  - CaptureDR and UpdateDR are ignored.
  - Reset clears BB to 0.
REQ-028 With SCAN_DR_BYPASS_EN defined and Bypass = 0, behaviour SHALL be identical to REQ-015 to REQ-025.
REQ-029 Without SCAN_DR_BYPASS_EN, the Bypass port and BB SHALL NOT exist, and the full chain SHALL always be selected.

Verification
REQ-030 WIDTH=8: pulse Reset, Mode=1 -> ParallelOut=0x00, TDO=0, ShiftCount=0, ShiftDone=0.
REQ-031 ParallelIn=0xA5, CaptureDR 1 cycle, then ShiftDR 8 cycles with TDI=0 -> TDO sequence 1,0,1,0,0,1,0,1; ShiftDone=1 after the 8th edge.
REQ-032 Shift in 0x3C LSB-first (8 edges), then UpdateDR for 1 cycle:
  - Mode=1 -> ParallelOut=0x3C.
  - Mode=0 with ParallelIn=0x55 -> ParallelOut=0x55.
REQ-033 ShiftDR high for 12 edges -> ShiftCount=8 and stays 8; then CaptureDR and ShiftDR high together -> SR=ParallelIn, ShiftCount=0.
REQ-034 Reset high after 3 shift edges -> SR=0, ShiftCount=0, UR=RESET_VALUE; UpdateDR in that same cycle has no effect.
REQ-035 With SCAN_DR_BYPASS_EN and Bypass=1:
  - TDI=1, ShiftDR=1 -> TDO=1 after 1 edge.
  - ShiftDR=0 -> TDO=0 after the next edge.
  - SR and ShiftCount unchanged throughout.

Source files
------------

// File: rtl/scan_data_register.sv
// rtl/scan_data_register.sv - JTAG-style capture/shift/update data register with shift counter
// Optional single-bit bypass path enabled by defining SCAN_DR_BYPASS_EN.
module scan_data_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       ClockDR,
  input  logic                       Reset,
  input  logic                       TDI,
  input  logic                       CaptureDR,
  input  logic                       ShiftDR,
  input  logic                       UpdateDR,
  input  logic                       Mode,
`ifdef SCAN_DR_BYPASS_EN
  input  logic                       Bypass,
`endif
  input  logic [WIDTH-1:0]           ParallelIn,
  output logic [WIDTH-1:0]           ParallelOut,
  output logic                       TDO,
  output logic [$clog2(WIDTH+1)-1:0] ShiftCount,
  output logic                       ShiftDone
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [WIDTH-1:0] sr_d, sr_q;
  logic [WIDTH-1:0] ur_d, ur_q;
  logic [WIDTH-1:0] sr_shift;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             byp;

`ifdef SCAN_DR_BYPASS_EN
  logic bb_d, bb_q;

  assign byp  = Bypass;
  assign bb_d = TDI & ShiftDR;

  always_ff @(posedge ClockDR) begin
    if (Reset) begin
      bb_q <= 1'b0;
    end else begin
      bb_q <= bb_d;
    end
  end

  assign TDO = byp ? bb_q : sr_q[0];
`else
  assign byp = 1'b0;
  assign TDO = sr_q[0];
`endif

  // Shift right with TDI entering at the MSB; also valid for WIDTH == 1.
  always_comb begin
    sr_shift            = sr_q >> 1;
    sr_shift[WIDTH-1]   = TDI;
  end

  always_comb begin
    sr_d  = sr_q;
    ur_d  = ur_q;
    cnt_d = cnt_q;
    if (!byp) begin
      if (UpdateDR) begin
        ur_d = sr_q;
      end
      if (CaptureDR) begin
        sr_d  = ParallelIn;
        cnt_d = '0;
      end else if (ShiftDR) begin
        sr_d = sr_shift;
        if (cnt_q != FULL) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge ClockDR) begin
    if (Reset) begin
      sr_q  <= '0;
      ur_q  <= RESET_VALUE;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      ur_q  <= ur_d;
      cnt_q <= cnt_d;
    end
  end

  assign ParallelOut = Mode ? ur_q : ParallelIn;
  assign ShiftCount  = cnt_q;
  assign ShiftDone   = (cnt_q == FULL);

endmodule

// File: tb/tb_scan_data_register.sv
// tb/tb_scan_data_register.sv - randomized self-checking bench for scan_data_register
// Bypass stimulus is included only when SCAN_DR_BYPASS_EN is defined.
module tb_scan_data_register;

  localparam int               WIDTH = 8;
  localparam int               CW    = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] RV    = '0;

  logic             ClockDR = 1'b0;
  logic             Reset, TDI, CaptureDR, ShiftDR, UpdateDR, Mode, byp;
  logic [WIDTH-1:0] ParallelIn, ParallelOut;
  logic             TDO;
  logic [CW-1:0]    ShiftCount;
  logic             ShiftDone;

`ifdef SCAN_DR_BYPASS_EN
  logic Bypass;
  assign Bypass = byp;
`endif

  always #5 ClockDR = ~ClockDR;

  scan_data_register #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .ClockDR    (ClockDR),
    .Reset      (Reset),
    .TDI        (TDI),
    .CaptureDR  (CaptureDR),
    .ShiftDR    (ShiftDR),
    .UpdateDR   (UpdateDR),
    .Mode       (Mode),
`ifdef SCAN_DR_BYPASS_EN
    .Bypass     (Bypass),
`endif
    .ParallelIn (ParallelIn),
    .ParallelOut(ParallelOut),
    .TDO        (TDO),
    .ShiftCount (ShiftCount),
    .ShiftDone  (ShiftDone)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the chain is a bit list with element 0 nearest TDO.
  bit msr[$];
  int mur, mcnt;
  bit mbb;
  bit model_ok = 1'b0;

  function automatic int sr_val();
    int v = 0;
    for (int i = 0; i < WIDTH; i++) if (msr[i]) v |= (1 << i);
    return v;
  endfunction

  always @(posedge ClockDR) begin
    if (Reset) begin
      msr.delete();
      repeat (WIDTH) msr.push_back(1'b0);
      mur      = int'(RV);
      mcnt     = 0;
      mbb      = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      mbb = TDI & ShiftDR;
      if (!byp) begin
        if (UpdateDR) mur = sr_val();
        if (CaptureDR) begin
          msr.delete();
          for (int i = 0; i < WIDTH; i++) msr.push_back(ParallelIn[i]);
          mcnt = 0;
        end else if (ShiftDR) begin
          void'(msr.pop_front());
          msr.push_back(TDI);
          if (mcnt < WIDTH) mcnt++;
        end
      end
    end
  end

  always @(negedge ClockDR) begin
    if (model_ok) begin
      logic             exp_tdo;
      logic [WIDTH-1:0] exp_po;
      logic [31:0]      ur_bits;
      ur_bits = mur;
      exp_tdo = byp ? mbb : msr[0];
      exp_po  = Mode ? ur_bits[WIDTH-1:0] : ParallelIn;
      check("tdo", 32'(TDO), 32'(exp_tdo));
      check("shift_count", 32'(ShiftCount), mcnt);
      check("shift_done", 32'(ShiftDone), 32'(mcnt == WIDTH));
      check("parallel_out", 32'(ParallelOut), 32'(exp_po));
    end
  end

  task automatic tick();
    @(posedge ClockDR);
    #1;
  endtask

  task automatic idle();
    CaptureDR = 1'b0;
    ShiftDR   = 1'b0;
    UpdateDR  = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    idle();
    Reset = 1'b1; Mode = 1'b1; ParallelIn = '0; TDI = 1'b0; byp = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    #1;
    check("lit_reset_pout", 32'(ParallelOut), 32'h00);
    check("lit_reset_tdo", 32'(TDO), 32'h0);
    check("lit_reset_count", 32'(ShiftCount), 32'h0);
    check("lit_reset_done", 32'(ShiftDone), 32'h0);

    ParallelIn = 8'hA5; CaptureDR = 1'b1;
    tick();
    CaptureDR = 1'b0;
    pat = 8'b1010_0101;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("lit_a5_tdo_%0d", k), 32'(TDO), 32'(pat[k]));
      ShiftDR = 1'b1; TDI = 1'b0;
      tick();
    end
    ShiftDR = 1'b0;
    check("lit_a5_done", 32'(ShiftDone), 32'h1);
    check("lit_a5_count", 32'(ShiftCount), 32'd8);

    pat = 8'h3C;
    ShiftDR = 1'b1;
    for (int k = 0; k < 8; k++) begin
      TDI = pat[k];
      tick();
    end
    ShiftDR = 1'b0; UpdateDR = 1'b1;
    tick();
    UpdateDR = 1'b0;
    check("lit_upd_mode1", 32'(ParallelOut), 32'h3C);
    Mode = 1'b0; ParallelIn = 8'h55;
    #1;
    check("lit_upd_mode0", 32'(ParallelOut), 32'h55);
    Mode = 1'b1;

    ShiftDR = 1'b1;
    repeat (12) tick();
    check("lit_sat_count", 32'(ShiftCount), 32'd8);
    tick();
    check("lit_sat_hold", 32'(ShiftCount), 32'd8);
    CaptureDR = 1'b1; ParallelIn = 8'h96;
    tick();
    idle();
    check("lit_cap_pri_count", 32'(ShiftCount), 32'd0);
    check("lit_cap_pri_tdo", 32'(TDO), 32'h0);
    UpdateDR = 1'b1;
    tick();
    UpdateDR = 1'b0;
    check("lit_cap_pri_sr", 32'(ParallelOut), 32'h96);

    ShiftDR = 1'b1; TDI = 1'b1;
    repeat (3) tick();
    ShiftDR = 1'b0; Reset = 1'b1; UpdateDR = 1'b1;
    tick();
    Reset = 1'b0; UpdateDR = 1'b0;
    check("lit_midrst_pout", 32'(ParallelOut), 32'h00);
    check("lit_midrst_count", 32'(ShiftCount), 32'd0);
    check("lit_midrst_tdo", 32'(TDO), 32'h0);

`ifdef SCAN_DR_BYPASS_EN
    byp = 1'b1; TDI = 1'b1; ShiftDR = 1'b1;
    tick();
    check("lit_byp_tdo1", 32'(TDO), 32'h1);
    ShiftDR = 1'b0;
    tick();
    check("lit_byp_tdo0", 32'(TDO), 32'h0);
    check("lit_byp_count", 32'(ShiftCount), 32'd0);
    byp = 1'b0;
`endif

    repeat (800) begin
      Reset      = ($urandom_range(0, 39) == 0);
      CaptureDR  = ($urandom_range(0, 5) == 0);
      ShiftDR    = ($urandom_range(0, 1) == 0);
      UpdateDR   = ($urandom_range(0, 5) == 0);
      Mode       = 1'($urandom);
      TDI        = 1'($urandom);
      ParallelIn = WIDTH'($urandom);
`ifdef SCAN_DR_BYPASS_EN
      byp        = ($urandom_range(0, 3) == 0);
`endif
      tick();
    end
    Reset = 1'b0; byp = 1'b0;
    idle();
    tick();
    @(negedge ClockDR);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
